// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder: operands in via in_valid/in_ready,
// results out via out_valid/out_ready. The slave modport is the adder side.
interface pipelined_adder_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         Cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, x, y, Cin, sub, out_ready,
        input  in_ready, out_valid, s, Cout, ovf, zero
    );

    modport slave (
        input  in_valid, x, y, Cin, sub, out_ready,
        output in_ready, out_valid, s, Cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// N-bit add/sub resolved one W=N/STAGES chunk per stage; STAGES cycles latency, 1 op/cycle.
// Backpressure: whole pipe stalls while a result waits on out_ready; in_ready mirrors that.
module pipelined_adder #(
    parameter int N      = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int W = N / STAGES;

    logic         adv;
    logic         out_vld_q;
    logic [N-1:0] s_q;
    logic         cout_q;
    logic         ovf_q;
    logic         zero_q;

    assign adv           = !out_vld_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_vld_q;
    assign bus.s         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Stage k adds the low W bits of its remaining operands; the upper bits
    // and the resolved low sum travel to stage k+1 through its input register.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int REM = N - k * W;

        logic                 v_in;
        logic                 c_in;
        logic [REM-1:0]       a_in;
        logic [REM-1:0]       b_in;
        logic [(k+1)*W-1:0]   s_cur;
        logic [W:0]           chunk;

        assign chunk = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        if (k == 0) begin : g_entry
            assign v_in  = bus.in_valid;
            assign a_in  = bus.x;
            assign b_in  = bus.sub ? ~bus.y : bus.y;
            // Subtraction is x + ~y + ~Cin, so the borrow-in inverts.
            assign c_in  = bus.sub ^ bus.Cin;
            assign s_cur = chunk[W-1:0];
        end else begin : g_reg
            logic           v_q;
            logic           c_q;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic [k*W-1:0] ps_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    c_q  <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    ps_q <= '0;
                end else if (adv) begin
                    v_q  <= g_st[k-1].v_in;
                    c_q  <= g_st[k-1].chunk[W];
                    a_q  <= g_st[k-1].a_in[REM+W-1:W];
                    b_q  <= g_st[k-1].b_in[REM+W-1:W];
                    ps_q <= g_st[k-1].s_cur;
                end
            end

            assign v_in  = v_q;
            assign c_in  = c_q;
            assign a_in  = a_q;
            assign b_in  = b_q;
            assign s_cur = {chunk[W-1:0], ps_q};
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at bit N-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            s_q       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (adv) begin
            out_vld_q <= g_st[STAGES-1].v_in;
            s_q       <= g_st[STAGES-1].s_cur;
            cout_q    <= g_st[STAGES-1].chunk[W];
            ovf_q     <= g_st[STAGES-1].a_in[W-1] ^ g_st[STAGES-1].b_in[W-1]
                       ^ g_st[STAGES-1].chunk[W-1] ^ g_st[STAGES-1].chunk[W];
            zero_q    <= ~|g_st[STAGES-1].s_cur;
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: N=16/STAGES=4 directed + backpressure + reset, N=64 at STAGES=1 and 8 random.
module tb_pipelined_adder;
    typedef struct {
        logic [15:0] x, y;
        logic        cin, sub;
        logic [15:0] s;
        logic        cout, ovf, zero;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        cout, ovf, zero;
        int          due;
    } exp_t;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    pipelined_adder_if #(.N(16)) b16 ();
    pipelined_adder_if #(.N(64)) b1 ();
    pipelined_adder_if #(.N(64)) b8 ();

    pipelined_adder #(.N(16), .STAGES(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
    pipelined_adder #(.N(64), .STAGES(1)) u1  (.clk(clk), .rst(rst), .bus(b1));
    pipelined_adder #(.N(64), .STAGES(8)) u8  (.clk(clk), .rst(rst), .bus(b8));

    // Reference: exact integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input int n, input logic [63:0] x, input logic [63:0] y,
                                   input logic cin, input logic sub);
        exp_t               e;
        logic [65:0]        xu, yu, ru, c66;
        logic signed [65:0] xs, ys, rs, one, smax, smin;
        logic [63:0]        mask;
        one = 66'sd1;
        c66 = {65'd0, cin};
        xu  = {2'b00, x};
        yu  = {2'b00, y};
        xs  = $signed(xu);
        ys  = $signed(yu);
        if (x[n-1]) xs = xs - (one <<< n);
        if (y[n-1]) ys = ys - (one <<< n);
        if (!sub) begin
            ru     = xu + yu + c66;
            rs     = xs + ys + $signed(c66);
            e.cout = ru[n];
        end else begin
            ru     = xu - yu - c66;
            rs     = xs - ys - $signed(c66);
            e.cout = (xu >= yu + c66);
        end
        mask   = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        e.s    = ru[63:0] & mask;
        smax   = (one <<< (n - 1)) - one;
        smin   = -(one <<< (n - 1));
        e.ovf  = (rs > smax) || (rs < smin);
        e.zero = (e.s == 64'd0);
        e.due  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [67:0] obs16();
        return {b16.out_valid, 48'd0, b16.s, b16.Cout, b16.ovf, b16.zero};
    endfunction

    function automatic logic [67:0] obs1();
        return {b1.out_valid, b1.s, b1.Cout, b1.ovf, b1.zero};
    endfunction

    function automatic logic [67:0] obs8();
        return {b8.out_valid, b8.s, b8.Cout, b8.ovf, b8.zero};
    endfunction

    function automatic logic [67:0] want(input exp_t e);
        return {1'b1, e.s, e.cout, e.ovf, e.zero};
    endfunction

    // Streams nops operations through the 16-bit unit with a scoreboard queue.
    task automatic run16(input int nops, input bit rnd);
        exp_t        q[$];
        exp_t        e;
        int          issued = 0;
        int          got    = 0;
        int          cyc    = 0;
        int          extra  = 0;
        bit          acc    = 1'b0;
        bit          stall  = 1'b0;
        logic [67:0] held   = '0;
        b16.in_valid = 1'b0;
        while (got < nops && cyc < 20 * nops + 100) begin
            step();
            cyc++;
            if (stall) chk("hold", 128'(obs16()), 128'(held));
            if (!b16.in_valid || acc) begin
                if (issued < nops && (!rnd || $urandom_range(0, 3) != 0)) begin
                    b16.x        = rnd16();
                    b16.y        = rnd16();
                    b16.Cin      = 1'($urandom);
                    b16.sub      = 1'($urandom);
                    b16.in_valid = 1'b1;
                    issued++;
                end else begin
                    b16.in_valid = 1'b0;
                end
            end
            b16.out_ready = rnd ? ($urandom_range(0, 4) < 3) : (cyc % 3 == 1);
            #1;
            acc = b16.in_valid && b16.in_ready;
            if (acc) q.push_back(model(16, 64'(b16.x), 64'(b16.y), b16.Cin, b16.sub));
            if (b16.out_valid && b16.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious", 128'(b16.out_valid), 128'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream", 128'(obs16()), 128'(want(e)));
                    got++;
                end
            end
            stall = b16.out_valid && !b16.out_ready;
            held  = obs16();
        end
        b16.in_valid  = 1'b0;
        b16.out_ready = 1'b1;
        chk("count", 128'(got), 128'(nops));
        chk("pending", 128'(q.size()), 128'd0);
        repeat (8) begin
            step();
            if (b16.out_valid) extra++;
        end
        chk("extra", 128'(extra), 128'd0);
    endtask

    vec_t tbl[10];
    exp_t q1[$];
    exp_t q8[$];
    exp_t e;
    int   lat;
    int   stale;
    int   acc_n;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        b16.in_valid = 1'b0; b16.out_ready = 1'b1; b16.x = '0; b16.y = '0; b16.Cin = 1'b0; b16.sub = 1'b0;
        b1.in_valid  = 1'b0; b1.out_ready  = 1'b1; b1.x  = '0; b1.y  = '0; b1.Cin  = 1'b0; b1.sub  = 1'b0;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b1; b8.x  = '0; b8.y  = '0; b8.Cin  = 1'b0; b8.sub  = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset16", 128'({b16.out_valid, b16.in_ready, b16.Cout, b16.ovf, b16.zero, 48'd0, b16.s}),
            128'({1'b0, 1'b1, 3'b000, 64'd0}));
        chk("reset64s1", 128'({b1.out_valid, b1.in_ready, b1.Cout, b1.ovf, b1.zero, b1.s}),
            128'({1'b0, 1'b1, 3'b000, 64'd0}));
        chk("reset64s8", 128'({b8.out_valid, b8.in_ready, b8.Cout, b8.ovf, b8.zero, b8.s}),
            128'({1'b0, 1'b1, 3'b000, 64'd0}));

        for (int i = 0; i < 10; i++) begin
            step();
            b16.x        = tbl[i].x;
            b16.y        = tbl[i].y;
            b16.Cin      = tbl[i].cin;
            b16.sub      = tbl[i].sub;
            b16.in_valid = 1'b1;
            step();
            b16.in_valid = 1'b0;
            lat = 1;
            while (!b16.out_valid && lat < 20) begin
                step();
                lat++;
            end
            chk($sformatf("latency%0d", i), 128'(lat), 128'd4);
            chk($sformatf("vector%0d", i), 128'({b16.out_valid, b16.s, b16.Cout, b16.ovf, b16.zero}),
                128'({1'b1, tbl[i].s, tbl[i].cout, tbl[i].ovf, tbl[i].zero}));
        end

        run16(8, 1'b0);

        b16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            b16.x        = rnd16();
            b16.y        = rnd16();
            b16.Cin      = 1'($urandom);
            b16.sub      = 1'($urandom);
            b16.in_valid = 1'b1;
        end
        step();
        b16.in_valid = 1'b0;
        #1;
        chk("valid_before_reset", 128'(b16.out_valid), 128'd1);
        rst = 1'b1;
        #1;
        chk("valid_during_reset", 128'(b16.out_valid), 128'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 128'(b16.in_ready), 128'd1);
        stale = 0;
        repeat (12) begin
            step();
            if (b16.out_valid) stale++;
        end
        chk("stale_results", 128'(stale), 128'd0);

        run16(2000, 1'b1);

        acc_n = 0;
        for (int cyc = 0; cyc < 20 * NRAND; cyc++) begin
            step();
            if (acc_n < NRAND && $urandom_range(0, 3) != 0) begin
                b1.x   = rnd64();
                b1.y   = rnd64();
                b1.Cin = 1'($urandom);
                b1.sub = 1'($urandom);
                b1.in_valid = 1'b1;
            end else begin
                b1.in_valid = 1'b0;
            end
            b8.x = b1.x; b8.y = b1.y; b8.Cin = b1.Cin; b8.sub = b1.sub; b8.in_valid = b1.in_valid;
            #1;
            if (q1.size() != 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("rand64_s1", 128'(obs1()), 128'(want(e)));
            end else begin
                chk("idle64_s1", 128'(b1.out_valid), 128'd0);
            end
            if (q8.size() != 0 && q8[0].due == cyc) begin
                e = q8.pop_front();
                chk("rand64_s8", 128'(obs8()), 128'(want(e)));
            end else begin
                chk("idle64_s8", 128'(b8.out_valid), 128'd0);
            end
            if (b1.in_valid) begin
                chk("ready64", 128'({b1.in_ready, b8.in_ready}), 128'd3);
                e     = model(64, b1.x, b1.y, b1.Cin, b1.sub);
                e.due = cyc + 1;
                q1.push_back(e);
                e.due = cyc + 8;
                q8.push_back(e);
                acc_n++;
            end
            if (acc_n == NRAND && q1.size() == 0 && q8.size() == 0) break;
        end
        chk("drained64_s1", 128'(q1.size()), 128'd0);
        chk("drained64_s8", 128'(q8.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
